// File: rtl/ps_pixel_fifo.sv
// Single-clock pixel FIFO feeding the gaussian filter's request/valid input.
// Registered-read RAM, explicit fill counter, registered status flags, sticky overflow.
module ps_pixel_fifo #(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int AFULL_LVL = 1008
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_rd_req,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_fill,
  output logic              o_overflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LV = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_LV = (ADDR_W+1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   fill_q, fill_nxt;
  logic              empty_q, full_q, afull_q, ovf_q;
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;
  logic              clr, pop, push, drop;

  // Flags are registered, so a word written into an empty FIFO is not
  // visible to the read side until the following cycle (no bypass).
  assign clr  = i_rst | i_flush;
  assign pop  = i_rd_req & ~empty_q;
  assign push = i_wr & (~full_q | pop);
  assign drop = i_wr & full_q & ~pop;

  always_comb begin
    fill_nxt = fill_q;
    case ({push, pop})
      2'b10:   fill_nxt = fill_q + 1'b1;
      2'b01:   fill_nxt = fill_q - 1'b1;
      default: fill_nxt = fill_q;
    endcase
  end

  // Write port: array kept free of reset so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (push && !clr) mem[wr_ptr_q] <= i_wdata;
  end

  // Stage p0 -> p1: registered RAM read, valid travels with data
  always_ff @(posedge i_clk) begin
    if (clr) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= pop;
      if (pop) rdata_p1 <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q  <= fill_nxt;
      empty_q <= (fill_nxt == '0);
      full_q  <= (fill_nxt == DEPTH_LV);
      afull_q <= (fill_nxt >= AFULL_LV);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign o_full        = full_q;
  assign o_almost_full = afull_q;
  assign o_empty       = empty_q;
  assign o_fill        = fill_q;
  assign o_overflow    = ovf_q;
  assign o_rdata       = rdata_p1;
  assign o_rvalid      = vld_p1;

endmodule

// File: tb/tb_ps_pixel_fifo.sv
// Self-checking bench for ps_pixel_fifo: vector table for short sequences,
// hand-written sequences for fill/overflow, full pass-through, wrap and flush.
module tb_ps_pixel_fifo;

  localparam int DATA_W    = 12;
  localparam int ADDR_W    = 10;
  localparam int AFULL_LVL = 1008;

  logic              clk = 1'b0;
  logic              rst, flush, wr, rd_req;
  logic [DATA_W-1:0] wdata;
  logic              full, almost_full, rvalid, empty, overflow;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W:0]   fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps_pixel_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr(wr), .i_wdata(wdata),
    .o_full(full), .o_almost_full(almost_full), .i_rd_req(rd_req),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_empty(empty), .o_fill(fill),
    .o_overflow(overflow)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        wr;
    logic [11:0] wdata;
    logic        rd;
    logic        exp_rv;
    logic [11:0] exp_rd;
    int          exp_fill;
    logic        exp_empty;
    logic        exp_ov;
  } vec_t;

  vec_t vecs [12];
  logic [DATA_W-1:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic w, input logic [11:0] d,
                       input logic rq);
    rst = r; flush = f; wr = w; wdata = d; rd_req = rq;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d, din;

    // rst/flush/wr/wdata/rd -> rvalid/rdata/fill/empty/overflow after the edge
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 12'h005, 1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 12'h006, 1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 12'h000, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 12'h002, 1'b1, 1'b1, 12'h001, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h002, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 12'hABC, 1'b1, 1'b0, 12'h002, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'hABC, 0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'hABC, 0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 12'h111, 1'b0, 1'b0, 12'hABC, 1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 12'h222, 1'b1, 1'b0, 12'h000, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 0, 1'b1, 1'b0};

    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].wdata, vecs[i].rd);
      tick();
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d fill", i), 32'(fill), 32'(vecs[i].exp_fill));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d full", i), 32'(full), 32'd0);
    end

    // Ordering: 16 words then continuous read
    for (int n = 1; n <= 16; n++) begin
      drive(1'b0, 1'b0, 1'b1, 12'(n), 1'b0);
      tick();
    end
    chk("ord fill16", 32'(fill), 32'd16);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk($sformatf("ord rvalid%0d", n), 32'(rvalid), 32'd1);
      chk($sformatf("ord rdata%0d", n), 32'(rdata), 32'(n));
    end
    chk("ord empty", 32'(empty), 32'd1);
    tick();
    chk("ord rvalid after drain", 32'(rvalid), 32'd0);

    // Fill to 1024 with almost-full / full thresholds
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    for (int n = 1; n <= 1024; n++) begin
      drive(1'b0, 1'b0, 1'b1, 12'(n), 1'b0);
      tick();
      chk("fill count", 32'(fill), 32'(n));
      chk("almost_full", 32'(almost_full), 32'(n >= AFULL_LVL));
      chk("full", 32'(full), 32'(n == 1024));
    end
    // Simultaneous write and read at full: accepted, no overflow
    drive(1'b0, 1'b0, 1'b1, 12'hF00, 1'b1);
    tick();
    chk("full rw fill", 32'(fill), 32'd1024);
    chk("full rw overflow", 32'(overflow), 32'd0);
    chk("full rw rvalid", 32'(rvalid), 32'd1);
    chk("full rw rdata", 32'(rdata), 32'd1);
    chk("full rw full", 32'(full), 32'd1);
    // Write while full with no read: dropped
    drive(1'b0, 1'b0, 1'b1, 12'h555, 1'b0);
    tick();
    chk("drop fill", 32'(fill), 32'd1024);
    chk("drop overflow", 32'(overflow), 32'd1);
    chk("drop rvalid", 32'(rvalid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int n = 2; n <= 1025; n++) begin
      tick();
      chk("drain rvalid", 32'(rvalid), 32'd1);
      chk("drain rdata", 32'(rdata), (n == 1025) ? 32'h0F00 : 32'(n));
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain fill", 32'(fill), 32'd0);
    chk("overflow sticky", 32'(overflow), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("drain rvalid end", 32'(rvalid), 32'd0);

    // Streaming with ~512 words resident; pointers wrap several times
    for (int n = 0; n < 512; n++) begin
      din = 12'(n + 12'h300);
      drive(1'b0, 1'b0, 1'b1, din, 1'b0);
      q.push_back(din);
      tick();
    end
    for (int c = 0; c < 3000; c++) begin
      din = 12'(c * 7 + 5);
      drive(1'b0, 1'b0, 1'b1, din, 1'b1);
      tick();
      exp_d = q.pop_front();
      q.push_back(din);
      chk("stream rvalid", 32'(rvalid), 32'd1);
      chk("stream rdata", 32'(rdata), 32'(exp_d));
      chk("stream fill", 32'(fill), 32'd512);
    end
    // Drain down to 100 words
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 412; c++) begin
      tick();
      exp_d = q.pop_front();
      chk("part drain rdata", 32'(rdata), 32'(exp_d));
    end
    chk("part drain fill", 32'(fill), 32'd100);
    chk("overflow still set", 32'(overflow), 32'd1);

    // Flush with a pop in flight and a same-cycle write
    drive(1'b0, 1'b1, 1'b1, 12'h777, 1'b1);
    tick();
    chk("flush fill", 32'(fill), 32'd0);
    chk("flush empty", 32'(empty), 32'd1);
    chk("flush rvalid", 32'(rvalid), 32'd0);
    chk("flush overflow", 32'(overflow), 32'd0);
    chk("flush rdata", 32'(rdata), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 12'h3C3, 1'b0);
    tick();
    chk("post flush fill", 32'(fill), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    chk("post flush rvalid", 32'(rvalid), 32'd1);
    chk("post flush rdata", 32'(rdata), 32'h3C3);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("post flush empty", 32'(empty), 32'd1);
    chk("post flush rvalid end", 32'(rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
